rng_fsm: RTL and testbench
==========================

// Module: rng_fsm
//
// PURPOSE
// - Pairs a 32-bit pseudo-random number generator with a 3-bit Gray-code
//   sequencer FSM. Both are clocked by one clock and share one reset.
// - The RNG supplies random words to downstream Monte-Carlo logic.
// - The FSM steps a Gray-coded state under a 2-bit control input.
// - The two halves are functionally independent.
//
// PARAMETERS
// - SEED_DEFAULT  32'h12345678  RNG value at reset; also the substitute for a zero seed
//
// PORTS
// - clk         in   1   system clock; all flops update on the rising edge
// - rst         in   1   reset; synchronous, active-low
// - loadseed_i  in   1   1 = load seed_i into the RNG on this edge
// - seed_i      in   32  seed value
// - ctrl_i      in   2   FSM control: [1] = step enable, [0] = direction (1 = reverse)
// - number_o    out  32  RNG state, registered
// - state_o     out  3   FSM state, registered, Gray-coded
//
// BEHAVIOUR
// - Reset is sampled only on the clk rising edge, with rst == 0.
//   - number_o <= SEED_DEFAULT.
//   - state_o  <= 3'b000.
//   - Reset has top priority over all other inputs.
// - RNG: 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1 (maximal length).
//   - fb = r[31]^r[21]^r[1]^r[0]; next = {r[30:0], fb}.
//   - Priority: reset > loadseed_i > step.
//   - loadseed_i == 1: number_o = seed_i after the edge, with no shift on that edge.
//   - Otherwise the LFSR steps on every edge. There is no enable.
//   - Latency: a loaded seed appears 1 cycle after the load edge.
//     The first stepped value appears on the following edge.
// - FSM: 8 states in Gray order: S0..S7 = 000,001,011,010,110,111,101,100.
//   - ctrl_i = 0x: hold.
//   - ctrl_i = 10: advance to the next state in the order; S7 wraps to S0.
//   - ctrl_i = 11: move back to the previous state; S0 wraps to S7.
//   - Exactly one state bit changes per step.
//   - Decoding from the Gray order is explicit: a case statement on state_o.
//   - Any unreachable code maps to S0 on the next edge.
// - Simultaneous events: loadseed_i and FSM stepping are independent.
//   - Both may act on the same edge.
//   - Reset asserted mid-sequence overrides both on that edge.
//
// CONFIGURATION
// - RNG_ZERO_GUARD_EN defined:
//   - Loading seed_i == 0 stores SEED_DEFAULT instead, so the all-zero lockup state cannot occur.
// - RNG_ZERO_GUARD_EN undefined:
//   - seed_i == 0 is stored as-is.
//   - number_o then stays 0 until the next reset or load.
//
// TESTING
// - rst=0 for 2 edges, then 1 -> number_o=12345678h and state_o=000 at release.
//   Next edges give 2468ACF1h, then 48D159E2h.
// - loadseed_i=1 with seed_i=12345678h for 1 edge -> number_o=12345678h.
//   The next edge gives 2468ACF1h.
// - ctrl_i=10 for 8 edges from S0 -> state_o = 001,011,010,110,111,101,100,000 (wrap).
// - ctrl_i=11 from S0 -> state_o=100 (wrap to S7).
//   ctrl_i=00 or 01 -> state_o holds for 5 edges.
// - Load seed_i=0 -> with RNG_ZERO_GUARD_EN, number_o=12345678h;
//   without it, number_o stays 00000000h.
// - rst=0 asserted with loadseed_i=1 and ctrl_i=10 on the same edge
//   -> number_o=12345678h and state_o=000 (reset wins).

Source files
------------

// File: rtl/rng_fsm_if.sv
// rng_fsm_if: groups the data/control signals of rng_fsm.
// The master side drives the seed load and FSM control, and the slave side
// returns the registered RNG word and the Gray-coded FSM state.
// These signals have no valid/ready handshake. Inputs are sampled on every rising
// edge, and outputs are registered and valid in every cycle.
interface rng_fsm_if;
    logic        loadseed_i;
    logic [31:0] seed_i;
    logic [1:0]  ctrl_i;
    logic [31:0] number_o;
    logic [2:0]  state_o;

    modport master (
        output loadseed_i,
        output seed_i,
        output ctrl_i,
        input  number_o,
        input  state_o
    );

    modport slave (
        input  loadseed_i,
        input  seed_i,
        input  ctrl_i,
        output number_o,
        output state_o
    );
endinterface

// File: rtl/rng_fsm.sv
// rng_fsm: a 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1) plus an independent
// 3-bit Gray-code sequencer FSM. Both share clk and a synchronous
// active-low reset.
// Optional feature macro: RNG_ZERO_GUARD_EN. When it is defined, a zero seed is
// replaced by SEED_DEFAULT so that the LFSR cannot lock up at all zeros.
module rng_fsm #(
    parameter logic [31:0] SEED_DEFAULT = 32'h12345678
) (
    input  logic        clk,
    input  logic        rst,
    rng_fsm_if.slave    bus
);

    // ---------------- RNG ----------------
    logic [31:0] number_q;
    logic [31:0] seed_load;
    logic        fb;

    assign fb = number_q[31] ^ number_q[21] ^ number_q[1] ^ number_q[0];

    // Choose the value stored on a seed load (zero-guarded when enabled)
    always_comb begin
        seed_load = bus.seed_i;
`ifdef RNG_ZERO_GUARD_EN
        if (bus.seed_i == 32'h0) begin
            seed_load = SEED_DEFAULT;
        end
`else
        seed_load = bus.seed_i;
`endif
    end

    // LFSR register: reset > load > free-running step
    always_ff @(posedge clk) begin
        if (!rst) begin
            number_q <= SEED_DEFAULT;
        end else if (bus.loadseed_i) begin
            number_q <= seed_load;
        end else begin
            number_q <= {number_q[30:0], fb};
        end
    end

    assign bus.number_o = number_q;

    // ---------------- Gray sequencer FSM ----------------
    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b011,
        S3 = 3'b010,
        S4 = 3'b110,
        S5 = 3'b111,
        S6 = 3'b101,
        S7 = 3'b100
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t state_fwd;
    state_t state_rev;

    // State register; this register also drives state_o, the debug view of the FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: explicit Gray-order neighbours, then apply ctrl_i
    always_comb begin
        state_fwd = S0;
        state_rev = S0;
        state_d   = state_q;
        case (state_q)
            S0: begin state_fwd = S1; state_rev = S7; end
            S1: begin state_fwd = S2; state_rev = S0; end
            S2: begin state_fwd = S3; state_rev = S1; end
            S3: begin state_fwd = S4; state_rev = S2; end
            S4: begin state_fwd = S5; state_rev = S3; end
            S5: begin state_fwd = S6; state_rev = S4; end
            S6: begin state_fwd = S7; state_rev = S5; end
            S7: begin state_fwd = S0; state_rev = S6; end
            default: begin state_fwd = S0; state_rev = S0; end
        endcase
        case (state_q)
            S0, S1, S2, S3, S4, S5, S6, S7: begin
                if (bus.ctrl_i[1]) begin
                    state_d = bus.ctrl_i[0] ? state_rev : state_fwd;
                end
            end
            // Codes outside the Gray order recover to S0
            default: state_d = S0;
        endcase
    end

    assign bus.state_o = state_q;

endmodule

// File: tb/tb_rng_fsm.sv
// tb_rng_fsm: self-checking bench for rng_fsm. A reference model predicts
// each edge, pushes the prediction into exp_q, and compares it after the edge.
// Optional macro RNG_ZERO_GUARD_EN must match the DUT build.
module tb_rng_fsm;

    localparam logic [31:0] SEED_DEFAULT = 32'h12345678;

    logic clk;
    logic rst;
    rng_fsm_if bus ();

    rng_fsm #(.SEED_DEFAULT(SEED_DEFAULT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [34:0] exp_q[$];
    logic [31:0] m_num;
    int          m_idx;
    logic [2:0]  gray_tbl [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                    3'b110, 3'b111, 3'b101, 3'b100};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    endfunction

    // Drive one edge worth of inputs, predict the result, then compare after the edge
    task automatic drive_cycle(input logic rst_v, input logic load_v,
                               input logic [31:0] seed_v, input logic [1:0] ctrl_v,
                               input string tag);
        logic [34:0] e;
        @(negedge clk);
        rst            = rst_v;
        bus.loadseed_i = load_v;
        bus.seed_i     = seed_v;
        bus.ctrl_i     = ctrl_v;
        if (!rst_v) begin
            m_num = SEED_DEFAULT;
            m_idx = 0;
        end else begin
            if (load_v) begin
`ifdef RNG_ZERO_GUARD_EN
                m_num = (seed_v == 32'h0) ? SEED_DEFAULT : seed_v;
`else
                m_num = seed_v;
`endif
            end else begin
                m_num = lfsr_step(m_num);
            end
            if (ctrl_v[1]) begin
                m_idx = ctrl_v[0] ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
            end
        end
        exp_q.push_back({m_num, gray_tbl[m_idx]});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_num"}, bus.number_o, e[34:3]);
            check_val({tag, "_state"}, {29'd0, bus.state_o}, {29'd0, e[2:0]});
        end
    endtask

    initial begin
        logic [2:0] hold_state;
        rst            = 1'b0;
        bus.loadseed_i = 1'b0;
        bus.seed_i     = 32'h0;
        bus.ctrl_i     = 2'b00;
        m_num          = SEED_DEFAULT;
        m_idx          = 0;

        // Reset for two edges, then release
        drive_cycle(1'b0, 1'b0, 32'h0, 2'b00, "reset0");
        drive_cycle(1'b0, 1'b0, 32'h0, 2'b00, "reset1");
        check_val("reset_num_const", bus.number_o, 32'h12345678);
        check_val("reset_state_const", {29'd0, bus.state_o}, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'h0, 2'b00, "step1");
        check_val("step1_const", bus.number_o, 32'h2468ACF1);
        drive_cycle(1'b1, 1'b0, 32'h0, 2'b00, "step2");
        check_val("step2_const", bus.number_o, 32'h48D159E2);

        // Seed load then step
        drive_cycle(1'b1, 1'b1, 32'h12345678, 2'b00, "load");
        check_val("load_const", bus.number_o, 32'h12345678);
        drive_cycle(1'b1, 1'b0, 32'h0, 2'b00, "load_step");
        check_val("load_step_const", bus.number_o, 32'h2468ACF1);

        // Forward through all eight states with wrap
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0, 2'b10, "fwd");
        end
        check_val("fwd_wrap_const", {29'd0, bus.state_o}, 32'd0);

        // Reverse from S0 wraps to S7
        drive_cycle(1'b1, 1'b0, 32'h0, 2'b11, "rev");
        check_val("rev_wrap_const", {29'd0, bus.state_o}, {29'd0, 3'b100});

        // Hold for five edges with ctrl 00/01
        hold_state = bus.state_o;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0, (i % 2 == 0) ? 2'b00 : 2'b01, "hold");
        end
        check_val("hold_const", {29'd0, bus.state_o}, {29'd0, 3'b100});

        // Random mixed traffic
        for (int i = 0; i < 200; i++) begin
            logic        ld;
            logic [31:0] sd;
            ld = ($urandom_range(0, 7) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (sd == 32'h0 && ld) sd = 32'h0000_0001 << $urandom_range(0, 31);
            drive_cycle(1'b1, ld, sd, 2'($urandom_range(0, 3)), "rand");
        end

        // Zero seed
        drive_cycle(1'b1, 1'b1, 32'h0, 2'b10, "zero_load");
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0, 2'b00, "zero_step");
        end
`ifdef RNG_ZERO_GUARD_EN
        check_val("zero_guard_const", bus.number_o,
                  lfsr_step(lfsr_step(lfsr_step(32'h12345678))));
`else
        check_val("zero_stuck_const", bus.number_o, 32'h0);
`endif

        // Reset mid-sequence wins over load and step
        drive_cycle(1'b1, 1'b1, 32'hDEADBEEF, 2'b10, "pre_rst");
        drive_cycle(1'b0, 1'b1, 32'hCAFEF00D, 2'b10, "mid_rst");
        check_val("mid_rst_num_const", bus.number_o, 32'h12345678);
        check_val("mid_rst_state_const", {29'd0, bus.state_o}, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'h0, 2'b10, "post_rst");

        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
